commit_stage: RTL and testbench
===============================

COMMIT_STAGE -- requirements
Module: commit_stage

Interface
REQ-001 SHALL have ports: clk in 1, rstN in 1 (async active-low); one clock, reset asynchronous and active-low.
REQ-002 SHALL have inputs from execute: exValid 1, exPc 32, exInsn 32, exOp Op, exDstIntRegValue 32, exDstFpRegValue 64, exBranchTaken 1, exBranchTarget 32, exTrapInfo TrapInfo (valid, cause 4, value 32), exTrapReturn 1.
REQ-003 SHALL have input csrTrapVector 32 (handler address) and csrEpc 32 (return address).
REQ-004 SHALL have outputs intRegWriteEnable 1, intRegWriteAddr 5, intRegWriteValue 32, fpRegWriteEnable 1, fpRegWriteAddr 5, fpRegWriteValue 64.
REQ-005 SHALL have outputs csrTrapWrite 1, csrTrapEpc 32, csrTrapCause 4, csrTrapValue 32, csrTrapReturn 1.
REQ-006 SHALL have outputs redirectValid 1, redirectTarget 32, flush 1, stall 1, instRetired 64.

Function
REQ-007 SHALL latch all ex* inputs into a commit register each cycle stall=0; all commit actions act on the latched copy (1-cycle latency).
REQ-008 SHALL hold FSM states NORMAL, TRAP_SAVE, TRAP_REDIRECT.
REQ-009 In NORMAL with latched valid and no trap: SHALL assert intRegWriteEnable iff op.intRegWrite and rd != 0; fpRegWriteEnable iff op.fpRegWrite (x0 allowed for fp).
REQ-010 In NORMAL, latched valid, branchTaken, no trap: SHALL assert redirectValid and flush for exactly 1 cycle, redirectTarget = branchTarget.
REQ-011 In NORMAL, latched valid, trapReturn, no trap: SHALL assert csrTrapReturn, redirectValid, flush 1 cycle, redirectTarget = csrEpc.
REQ-012 In NORMAL, latched valid, trapInfo.valid: SHALL suppress register writes and branch redirect, go to TRAP_SAVE.
REQ-013 In TRAP_SAVE: SHALL assert csrTrapWrite 1 cycle with epc = latched pc, cause, value; stall=1; go to TRAP_REDIRECT.
REQ-014 In TRAP_REDIRECT: SHALL assert redirectValid, flush, target = csrTrapVector; stall=1; go to NORMAL.
REQ-015 stall SHALL be 1 exactly in TRAP_SAVE and TRAP_REDIRECT; commit register holds while stall=1.
REQ-016 On any flush cycle, the value latched next cycle SHALL be forced invalid (wrong-path squash).
REQ-017 trap priority > trapReturn > branchTaken when several set simultaneously.
REQ-018 instRetired SHALL increment by 1 per latched valid non-trapping instruction; wraps modulo 2^64.
REQ-019 Latched valid=0 SHALL produce no writes, redirects, or counter change.

Reset
REQ-020 On rstN low (asynchronous): state NORMAL, commit register valid 0, instRetired 0, all enables/strobes/redirect/flush/stall 0, data outputs 0.
REQ-021 Reset mid-trap SHALL abandon the trap with no csrTrapWrite after deassert.

Structure
REQ-022 State enum (CommitState) and TrapInfo/Op SHALL live in the shared RafiTypes package; widths from RvTypes.
REQ-023 Single module; optional sub-module commit_reg for the latch/squash register.

Verification
REQ-024 addi rd=5 value 0x1234 valid -> next cycle intRegWriteEnable=1, addr 5, value 0x1234, instRetired 0->1.
REQ-025 rd=0 intRegWrite -> intRegWriteEnable=0, instRetired increments.
REQ-026 branchTaken target 0x8000_0100, next-cycle valid insn -> redirect 1 cycle to 0x8000_0100; following insn squashed, no write.
REQ-027 trap cause 2 pc 0x8000_0040 value 0xDEAD, csrTrapVector 0x8000_0200 -> TRAP_SAVE (csrTrapWrite epc 0x8000_0040 cause 2), then redirect to 0x8000_0200, stall 2 cycles, no write, counter unchanged.
REQ-028 trap+branchTaken+trapReturn together -> trap path only.
REQ-029 rstN low during TRAP_SAVE -> outputs 0 immediately, NORMAL after release, no csrTrapWrite.

Source files
------------

// File: rtl/commit_stage_pkg.sv
// Shared type packages for the commit stage.
//   RvTypes   : architectural widths (XLEN, FLEN, register address, trap cause,
//               retire counter) and the word types built from them.
//   RafiTypes : commit FSM state enum, execute-side Op/TrapInfo records, the
//               latched commit entry, and a helper that extracts rd from an insn.
package RvTypes;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned FLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CAUSE_W    = 4;
    localparam int unsigned CTR_W      = 64;

    typedef logic [XLEN-1:0]       Word;
    typedef logic [FLEN-1:0]       FpWord;
    typedef logic [REG_ADDR_W-1:0] RegAddr;
    typedef logic [CAUSE_W-1:0]    Cause;
endpackage

package RafiTypes;
    import RvTypes::*;

    typedef enum logic [1:0] {
        NORMAL,
        TRAP_SAVE,
        TRAP_REDIRECT
    } CommitState;

    typedef struct packed {
        logic intRegWrite;
        logic fpRegWrite;
    } Op;

    typedef struct packed {
        logic valid;
        Cause cause;
        Word  value;
    } TrapInfo;

    typedef struct packed {
        logic    valid;
        Word     pc;
        Word     insn;
        Op       op;
        Word     intValue;
        FpWord   fpValue;
        logic    branchTaken;
        Word     branchTarget;
        TrapInfo trapInfo;
        logic    trapReturn;
    } CommitEntry;

    // Destination register field of a standard RISC-V encoding.
    function automatic RegAddr insnRd(input Word insn);
        return insn[11:7];
    endfunction
endpackage

// File: rtl/commit_stage_if.sv
// Execute -> commit bundle.
//   master : execute stage, drives every ex* signal.
//   slave  : commit stage, samples every ex* signal.
interface commit_stage_if;
    import RvTypes::*;
    import RafiTypes::*;

    logic    exValid;
    Word     exPc;
    Word     exInsn;
    Op       exOp;
    Word     exDstIntRegValue;
    FpWord   exDstFpRegValue;
    logic    exBranchTaken;
    Word     exBranchTarget;
    TrapInfo exTrapInfo;
    logic    exTrapReturn;

    modport master (
        output exValid, exPc, exInsn, exOp, exDstIntRegValue, exDstFpRegValue,
               exBranchTaken, exBranchTarget, exTrapInfo, exTrapReturn
    );

    modport slave (
        input  exValid, exPc, exInsn, exOp, exDstIntRegValue, exDstFpRegValue,
               exBranchTaken, exBranchTarget, exTrapInfo, exTrapReturn
    );
endinterface

// File: rtl/commit_stage_commit_reg.sv
// Commit register: latches one execute result per cycle.
//   clk, rstN : clock, asynchronous active-low reset (clears the entry).
//   load      : capture d this cycle.
//   squash    : force the stored entry invalid (wrong-path kill).
//   d, q      : incoming and latched commit entries.
module commit_reg
    import RafiTypes::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic       load,
    input  logic       squash,
    input  CommitEntry d,
    output CommitEntry q
);

    // Squash while holding only clears valid, so a trapping entry held across
    // the redirect cycle is retired from the register without a reload.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            q <= '0;
        end else if (load) begin
            q       <= d;
            q.valid <= d.valid & ~squash;
        end else if (squash) begin
            q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/commit_stage.sv
// Commit stage: retires the latched execute result one cycle after capture.
//   clk, rstN        : clock, asynchronous active-low reset.
//   ex               : execute-side bundle (slave modport).
//   csrTrapVector    : trap handler address; csrEpc : trap return address.
//   intRegWrite*     : integer register file write port (x0 never written).
//   fpRegWrite*      : FP register file write port.
//   csrTrap*         : trap save strobe with epc/cause/value; trap-return strobe.
//   redirectValid/Target, flush : front-end redirect and pipeline flush.
//   stall            : high while a trap is being taken.
//   instRetired      : 64-bit retired-instruction counter.
module commit_stage
    import RvTypes::*;
    import RafiTypes::*;
(
    input  logic               clk,
    input  logic               rstN,
    commit_stage_if.slave      ex,
    input  Word                csrTrapVector,
    input  Word                csrEpc,
    output logic               intRegWriteEnable,
    output RegAddr             intRegWriteAddr,
    output Word                intRegWriteValue,
    output logic               fpRegWriteEnable,
    output RegAddr             fpRegWriteAddr,
    output FpWord              fpRegWriteValue,
    output logic               csrTrapWrite,
    output Word                csrTrapEpc,
    output Cause               csrTrapCause,
    output Word                csrTrapValue,
    output logic               csrTrapReturn,
    output logic               redirectValid,
    output Word                redirectTarget,
    output logic               flush,
    output logic               stall,
    output logic [CTR_W-1:0]   instRetired
);

    CommitState state, stateNext;
    CommitEntry exEntry, c;
    logic       retire;
    logic       trapPending;
    logic       unusedInsnBits;

    always_comb begin
        exEntry              = '0;
        exEntry.valid        = ex.exValid;
        exEntry.pc           = ex.exPc;
        exEntry.insn         = ex.exInsn;
        exEntry.op           = ex.exOp;
        exEntry.intValue     = ex.exDstIntRegValue;
        exEntry.fpValue      = ex.exDstFpRegValue;
        exEntry.branchTaken  = ex.exBranchTaken;
        exEntry.branchTarget = ex.exBranchTarget;
        exEntry.trapInfo     = ex.exTrapInfo;
        exEntry.trapReturn   = ex.exTrapReturn;
    end

    // A trapping entry must survive until TRAP_SAVE reads its pc, so it is
    // held during the detect cycle even though stall is not yet raised.
    assign trapPending = (state == NORMAL) && c.valid && c.trapInfo.valid;

    commit_reg u_commit_reg (
        .clk    (clk),
        .rstN   (rstN),
        .load   (~stall & ~trapPending),
        .squash (flush),
        .d      (exEntry),
        .q      (c)
    );

    assign unusedInsnBits = ^{c.insn[31:12], c.insn[6:0]};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= NORMAL;
            instRetired <= '0;
        end else begin
            state <= stateNext;
            if (retire) begin
                instRetired <= instRetired + 1'b1;
            end
        end
    end

    always_comb begin
        stateNext         = state;
        retire            = 1'b0;
        intRegWriteEnable = 1'b0;
        intRegWriteAddr   = '0;
        intRegWriteValue  = '0;
        fpRegWriteEnable  = 1'b0;
        fpRegWriteAddr    = '0;
        fpRegWriteValue   = '0;
        csrTrapWrite      = 1'b0;
        csrTrapEpc        = '0;
        csrTrapCause      = '0;
        csrTrapValue      = '0;
        csrTrapReturn     = 1'b0;
        redirectValid     = 1'b0;
        redirectTarget    = '0;
        flush             = 1'b0;
        stall             = 1'b0;

        case (state)
            NORMAL: begin
                if (c.valid) begin
                    if (c.trapInfo.valid) begin
                        stateNext = TRAP_SAVE;
                    end else begin
                        retire = 1'b1;
                        if (c.op.intRegWrite && (insnRd(c.insn) != '0)) begin
                            intRegWriteEnable = 1'b1;
                            intRegWriteAddr   = insnRd(c.insn);
                            intRegWriteValue  = c.intValue;
                        end
                        if (c.op.fpRegWrite) begin
                            fpRegWriteEnable = 1'b1;
                            fpRegWriteAddr   = insnRd(c.insn);
                            fpRegWriteValue  = c.fpValue;
                        end
                        if (c.trapReturn) begin
                            csrTrapReturn  = 1'b1;
                            redirectValid  = 1'b1;
                            redirectTarget = csrEpc;
                            flush          = 1'b1;
                        end else if (c.branchTaken) begin
                            redirectValid  = 1'b1;
                            redirectTarget = c.branchTarget;
                            flush          = 1'b1;
                        end
                    end
                end
            end
            TRAP_SAVE: begin
                csrTrapWrite = 1'b1;
                csrTrapEpc   = c.pc;
                csrTrapCause = c.trapInfo.cause;
                csrTrapValue = c.trapInfo.value;
                stall        = 1'b1;
                stateNext    = TRAP_REDIRECT;
            end
            TRAP_REDIRECT: begin
                redirectValid  = 1'b1;
                redirectTarget = csrTrapVector;
                flush          = 1'b1;
                stall          = 1'b1;
                stateNext      = NORMAL;
            end
            default: begin
                stateNext = NORMAL;
            end
        endcase
    end

endmodule

// File: tb/tb_commit_stage.sv
module tb_commit_stage;
    import RvTypes::*;
    import RafiTypes::*;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    commit_stage_if exIf ();

    Word              csrTrapVector, csrEpc;
    logic             intRegWriteEnable, fpRegWriteEnable;
    RegAddr           intRegWriteAddr, fpRegWriteAddr;
    Word              intRegWriteValue;
    FpWord            fpRegWriteValue;
    logic             csrTrapWrite, csrTrapReturn;
    Word              csrTrapEpc, csrTrapValue;
    Cause             csrTrapCause;
    logic             redirectValid, flush, stall;
    Word              redirectTarget;
    logic [CTR_W-1:0] instRetired;

    commit_stage dut (
        .clk               (clk),
        .rstN              (rstN),
        .ex                (exIf),
        .csrTrapVector     (csrTrapVector),
        .csrEpc            (csrEpc),
        .intRegWriteEnable (intRegWriteEnable),
        .intRegWriteAddr   (intRegWriteAddr),
        .intRegWriteValue  (intRegWriteValue),
        .fpRegWriteEnable  (fpRegWriteEnable),
        .fpRegWriteAddr    (fpRegWriteAddr),
        .fpRegWriteValue   (fpRegWriteValue),
        .csrTrapWrite      (csrTrapWrite),
        .csrTrapEpc        (csrTrapEpc),
        .csrTrapCause      (csrTrapCause),
        .csrTrapValue      (csrTrapValue),
        .csrTrapReturn     (csrTrapReturn),
        .redirectValid     (redirectValid),
        .redirectTarget    (redirectTarget),
        .flush             (flush),
        .stall             (stall),
        .instRetired       (instRetired)
    );

    typedef struct {
        logic  v;
        Word   pc;
        RegAddr rd;
        logic  iw;
        logic  fw;
        Word   iv;
        FpWord fv;
        logic  bt;
        Word   btgt;
        logic  tret;
        Word   epc;
        logic  eIw;
        logic  eFw;
        logic  eRedir;
        Word   eTgt;
        logic  eTret;
        logic  eRet;
    } VecT;

    VecT              vecs [7];
    VecT              sb [$];
    VecT              e;
    int               checks = 0;
    int               errors = 0;
    logic [CTR_W-1:0] retModel = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input Word pc, input RegAddr rd, input logic iw,
                         input logic fw, input Word iv, input FpWord fv, input logic bt,
                         input Word btgt, input logic trv, input Cause cause,
                         input Word tval, input logic tret);
        exIf.exValid          = v;
        exIf.exPc             = pc;
        exIf.exInsn           = {20'h0, rd, 7'h13};
        exIf.exOp.intRegWrite = iw;
        exIf.exOp.fpRegWrite  = fw;
        exIf.exDstIntRegValue = iv;
        exIf.exDstFpRegValue  = fv;
        exIf.exBranchTaken    = bt;
        exIf.exBranchTarget   = btgt;
        exIf.exTrapInfo.valid = trv;
        exIf.exTrapInfo.cause = cause;
        exIf.exTrapInfo.value = tval;
        exIf.exTrapReturn     = tret;
    endtask

    task automatic bubble();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h8000_0000, 5'd5,  1'b1, 1'b0, 32'h1234, 64'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 32'h8000_0004, 5'd0,  1'b1, 1'b0, 32'h5555, 64'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'h8000_0008, 5'd0,  1'b0, 1'b1, 32'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h8000_000C, 5'd3,  1'b1, 1'b0, 32'h7, 64'h0, 1'b1, 32'h8000_0100, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h8000_0100, 5'd0,  1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0300,
                    1'b0, 1'b0, 1'b1, 32'h8000_0300, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 32'h8000_0104, 5'd7,  1'b1, 1'b1, 32'hFFFF, 64'h1, 1'b1, 32'h8000_0500, 1'b1, 32'h8000_0300,
                    1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h8000_0110, 5'd31, 1'b1, 1'b1, 32'hA5A5_A5A5, 64'h0123_4567_89AB_CDEF, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};

        rstN          = 1'b0;
        csrTrapVector = '0;
        csrEpc        = '0;
        bubble();
        #2;
        chk("rst intWE", intRegWriteEnable, 0);
        chk("rst intVal", intRegWriteValue, 0);
        chk("rst fpWE", fpRegWriteEnable, 0);
        chk("rst csrTrapWrite", csrTrapWrite, 0);
        chk("rst csrTrapReturn", csrTrapReturn, 0);
        chk("rst redirect", redirectValid, 0);
        chk("rst target", redirectTarget, 0);
        chk("rst flush", flush, 0);
        chk("rst stall", stall, 0);
        chk("rst instRetired", instRetired, 0);
        @(negedge clk);
        rstN = 1'b1;
        step();

        // Table vectors, each followed by a bubble to observe the counter.
        for (int i = 0; i < 7; i++) begin
            VecT v;
            v      = vecs[i];
            csrEpc = v.epc;
            drive(v.v, v.pc, v.rd, v.iw, v.fw, v.iv, v.fv, v.bt, v.btgt, 1'b0, '0, '0, v.tret);
            sb.push_back(v);
            step();
            e = sb.pop_front();
            chk($sformatf("v%0d intWE", i), intRegWriteEnable, e.eIw);
            if (e.eIw) begin
                chk($sformatf("v%0d intAddr", i), intRegWriteAddr, e.rd);
                chk($sformatf("v%0d intVal", i), intRegWriteValue, e.iv);
            end
            chk($sformatf("v%0d fpWE", i), fpRegWriteEnable, e.eFw);
            if (e.eFw) begin
                chk($sformatf("v%0d fpAddr", i), fpRegWriteAddr, e.rd);
                chk($sformatf("v%0d fpVal", i), fpRegWriteValue, e.fv);
            end
            chk($sformatf("v%0d redirect", i), redirectValid, e.eRedir);
            chk($sformatf("v%0d flush", i), flush, e.eRedir);
            if (e.eRedir) chk($sformatf("v%0d target", i), redirectTarget, e.eTgt);
            chk($sformatf("v%0d trapReturn", i), csrTrapReturn, e.eTret);
            chk($sformatf("v%0d stall", i), stall, 0);
            chk($sformatf("v%0d retiredBefore", i), instRetired, retModel);
            if (e.eRet) retModel = retModel + 1;
            bubble();
            step();
            chk($sformatf("v%0d retiredAfter", i), instRetired, retModel);
            chk($sformatf("v%0d bubbleFlush", i), flush, 0);
            chk($sformatf("v%0d bubbleIntWE", i), intRegWriteEnable, 0);
        end

        // Branch redirect squashes the instruction presented during the flush.
        drive(1'b1, 32'h8000_0200, 5'd2, 1'b1, 1'b0, 32'h9, '0, 1'b1, 32'h8000_0100, 1'b0, '0, '0, 1'b0);
        step();
        chk("br redirect", redirectValid, 1);
        chk("br target", redirectTarget, 32'h8000_0100);
        drive(1'b1, 32'h8000_0204, 5'd6, 1'b1, 1'b0, 32'h55, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        step();
        retModel = retModel + 1;
        chk("squash intWE", intRegWriteEnable, 0);
        chk("squash redirect", redirectValid, 0);
        chk("squash flush", flush, 0);
        chk("squash retired", instRetired, retModel);
        bubble();
        step();
        chk("squash noRetire", instRetired, retModel);

        // Trap: save, then redirect to the handler, two stall cycles.
        csrTrapVector = 32'h8000_0200;
        drive(1'b1, 32'h8000_0040, 5'd5, 1'b1, 1'b0, 32'h1234, '0, 1'b0, '0, 1'b1, 4'd2, 32'hDEAD, 1'b0);
        step();
        bubble();
        chk("trap0 intWE", intRegWriteEnable, 0);
        chk("trap0 redirect", redirectValid, 0);
        chk("trap0 stall", stall, 0);
        chk("trap0 csrTrapWrite", csrTrapWrite, 0);
        step();
        chk("trapSave write", csrTrapWrite, 1);
        chk("trapSave epc", csrTrapEpc, 32'h8000_0040);
        chk("trapSave cause", csrTrapCause, 2);
        chk("trapSave value", csrTrapValue, 32'hDEAD);
        chk("trapSave stall", stall, 1);
        chk("trapSave redirect", redirectValid, 0);
        step();
        chk("trapRedir write", csrTrapWrite, 0);
        chk("trapRedir redirect", redirectValid, 1);
        chk("trapRedir target", redirectTarget, 32'h8000_0200);
        chk("trapRedir flush", flush, 1);
        chk("trapRedir stall", stall, 1);
        step();
        chk("trapDone stall", stall, 0);
        chk("trapDone redirect", redirectValid, 0);
        chk("trapDone intWE", intRegWriteEnable, 0);
        chk("trapDone retired", instRetired, retModel);

        // Trap wins over trapReturn and branchTaken.
        csrTrapVector = 32'h8000_0400;
        csrEpc        = 32'h8000_0300;
        drive(1'b1, 32'h8000_0080, 5'd4, 1'b1, 1'b0, 32'h11, '0, 1'b1, 32'h8000_0100, 1'b1, 4'd3, 32'h0, 1'b1);
        step();
        bubble();
        chk("prio redirect", redirectValid, 0);
        chk("prio trapReturn", csrTrapReturn, 0);
        chk("prio flush", flush, 0);
        step();
        chk("prio save", csrTrapWrite, 1);
        chk("prio cause", csrTrapCause, 3);
        step();
        chk("prio target", redirectTarget, 32'h8000_0400);
        chk("prio trapReturn2", csrTrapReturn, 0);
        step();
        chk("prio stall", stall, 0);
        chk("prio retired", instRetired, retModel);

        // Reset during TRAP_SAVE abandons the trap.
        drive(1'b1, 32'h8000_00C0, 5'd1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 4'd5, 32'h1, 1'b0);
        step();
        bubble();
        step();
        chk("rstTrap save", csrTrapWrite, 1);
        rstN = 1'b0;
        #1;
        chk("rstTrap write", csrTrapWrite, 0);
        chk("rstTrap stall", stall, 0);
        chk("rstTrap redirect", redirectValid, 0);
        chk("rstTrap flush", flush, 0);
        chk("rstTrap retired", instRetired, 0);
        retModel = '0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rstTrap post%0d write", k), csrTrapWrite, 0);
            chk($sformatf("rstTrap post%0d stall", k), stall, 0);
        end
        drive(1'b1, 32'h8000_0000, 5'd5, 1'b1, 1'b0, 32'hBEEF, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        step();
        chk("rstTrap addi intWE", intRegWriteEnable, 1);
        chk("rstTrap addi intVal", intRegWriteValue, 32'hBEEF);
        bubble();
        step();
        retModel = retModel + 1;
        chk("rstTrap addi retired", instRetired, retModel);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
